// File: rtl/epu_sched_pkg.sv
// epu_sched_pkg: shared types and constants for the EPU layer scheduler
package epu_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_MODE, S_RD_W8, S_LATCH, S_ISSUE, S_WAIT, S_DONE, S_ERR
  } sched_state_e;
  localparam logic [3:0] MODE_RSVD = 4'hF;
  localparam logic OFS_MODE = 1'b0;
  localparam logic OFS_W8 = 1'b1;
endpackage

// File: rtl/epu_sched_wdog.sv
// epu_sched_wdog: per-layer watchdog; expires on the TIMEOUT_CYC-th enabled cycle after clear
module epu_sched_wdog #(
  parameter int TO_W = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [TO_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || clr_i) r_cnt <= '0;
    else if (en_i) r_cnt <= r_cnt + 1'b1;
  end
  assign expire_o = en_i && (r_cnt == TIMEOUT_CYC - 1'b1);
endmodule

// File: rtl/epu_layer_sched.sv
// epu_layer_sched: walks the layer-descriptor SRAM and sequences the convolution accelerator
module epu_layer_sched
  import epu_sched_pkg::*;
#(
  parameter int DESC_AW = 8,
  parameter int TO_W = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'hFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [DESC_AW-1:0] num_layers_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [DESC_AW-1:0] layer_idx_o,
  output logic               desc_cs_o,
  output logic [DESC_AW-1:0] desc_addr_o,
  input  logic [31:0]        desc_rdata_i,
  output logic               acc_start_o,
  output logic [3:0]         acc_mode_o,
  output logic [31:0]        acc_w8_o,
  input  logic               acc_finish_i
);
  sched_state_e r_state, w_next;
  logic [DESC_AW-1:0] r_idx, r_num;
  logic [3:0] r_mode, r_acc_mode;
  logic [31:0] r_w8;
  logic r_err, w_exp, w_last;

  epu_sched_wdog #(.TO_W(TO_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk(clk), .rst(rst), .clr_i(r_state == S_ISSUE), .en_i(r_state == S_WAIT), .expire_o(w_exp)
  );

  assign w_last = r_idx == r_num - 1'b1;

  // a finish in the expiry cycle wins over the timeout; abort overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_next = (num_layers_i == '0) ? S_DONE : S_RD_MODE;
      S_RD_MODE: w_next = S_RD_W8;
      S_RD_W8:   w_next = S_LATCH;
      S_LATCH:   w_next = (r_mode == MODE_RSVD) ? S_ERR : S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    w_next = acc_finish_i ? (w_last ? S_DONE : S_RD_MODE) : (w_exp ? S_ERR : S_WAIT);
      default:   w_next = S_IDLE;
    endcase
    if (abort_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_num      <= '0;
      r_mode     <= '0;
      r_acc_mode <= '0;
      r_w8       <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_num <= num_layers_i;
        r_idx <= '0;
        r_err <= 1'b0;
      end
      if (r_state == S_RD_W8) r_mode <= desc_rdata_i[3:0];
      if (r_state == S_LATCH) begin
        r_acc_mode <= r_mode;
        r_w8       <= desc_rdata_i;
      end
      if (r_state == S_WAIT && w_next == S_RD_MODE) r_idx <= r_idx + 1'b1;
      if (r_state != S_ERR && w_next == S_ERR) r_err <= 1'b1;
    end
  end

  assign busy_o      = r_state != S_IDLE;
  assign done_o      = r_state == S_DONE;
  assign err_o       = r_err;
  assign layer_idx_o = r_idx;
  assign desc_cs_o   = r_state == S_RD_MODE || r_state == S_RD_W8;
  assign desc_addr_o = {r_idx[DESC_AW-2:0], (r_state == S_RD_W8) ? OFS_W8 : OFS_MODE};
  assign acc_start_o = r_state == S_ISSUE;
  assign acc_mode_o  = r_acc_mode;
  assign acc_w8_o    = r_w8;
endmodule

// File: tb/tb_epu_layer_sched.sv
// tb_epu_layer_sched: directed checks of the layer scheduler against hand-computed values
module tb_epu_layer_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  num_layers_i = '0;
  logic        busy_o, done_o, err_o, desc_cs_o, acc_start_o;
  logic [7:0]  layer_idx_o, desc_addr_o;
  logic [31:0] desc_rdata_i = '0;
  logic [3:0]  acc_mode_o;
  logic [31:0] acc_w8_o;
  logic        acc_finish_i = 1'b0;
  logic [31:0] mem [0:255];
  int n_chk = 0, n_err = 0;
  int n_start = 0, n_done = 0, n_cs = 0;
  int b_start, b_done, b_cs;

  epu_layer_sched #(.DESC_AW(8), .TO_W(24), .TIMEOUT_CYC(24'd50)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .num_layers_i(num_layers_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .layer_idx_o(layer_idx_o),
    .desc_cs_o(desc_cs_o), .desc_addr_o(desc_addr_o), .desc_rdata_i(desc_rdata_i),
    .acc_start_o(acc_start_o), .acc_mode_o(acc_mode_o), .acc_w8_o(acc_w8_o),
    .acc_finish_i(acc_finish_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (desc_cs_o) desc_rdata_i <= mem[desc_addr_o];
    if (acc_start_o) n_start++;
    if (done_o) n_done++;
    if (desc_cs_o) n_cs++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_accstart"}, acc_start_o, 0);
    chk({tag, "_cs"}, desc_cs_o, 0);
    chk({tag, "_idx"}, layer_idx_o, 0);
    chk({tag, "_addr"}, desc_addr_o, 0);
    chk({tag, "_mode"}, acc_mode_o, 0);
    chk({tag, "_w8"}, acc_w8_o, 0);
  endtask

  task automatic snap();
    b_start = n_start;
    b_done = n_done;
    b_cs = n_cs;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'hABCD_0001; mem[1] = 32'h11;
    mem[2] = 32'h0000_0002; mem[3] = 32'h22;
    mem[4] = 32'h0000_0003; mem[5] = 32'h33;
    repeat (2) step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // three-layer run, finish 10 cycles after each start
    snap();
    start_i = 1'b1; num_layers_i = 8'd3;
    step();
    start_i = 1'b0;
    chk("c1_busy", busy_o, 1); chk("c1_cs", desc_cs_o, 1); chk("c1_addr", desc_addr_o, 0);
    step();
    chk("c2_cs", desc_cs_o, 1); chk("c2_addr", desc_addr_o, 1);
    step();
    chk("c3_cs", desc_cs_o, 0); chk("c3_accstart", acc_start_o, 0);
    step();
    for (int l = 0; l < 3; l++) begin
      chk("run_accstart", acc_start_o, 1);
      chk("run_mode", acc_mode_o, l + 1);
      chk("run_w8", acc_w8_o, 32'h11 * (l + 1));
      chk("run_idx", layer_idx_o, l);
      if (l == 1) begin start_i = 1'b1; num_layers_i = 8'd7; end
      step();
      start_i = 1'b0;
      chk("run_pulse_len", acc_start_o, 0);
      repeat (9) step();
      acc_finish_i = 1'b1;
      step();
      acc_finish_i = 1'b0;
      if (l < 2) begin
        chk("run_nodone", done_o, 0);
        repeat (3) step();
      end else begin
        chk("run_done", done_o, 1); chk("run_busy_at_done", busy_o, 1);
        step();
        chk("run_done_len", done_o, 0); chk("run_busy_fall", busy_o, 0);
      end
    end
    step();
    chk("run_nstart", n_start - b_start, 3);
    chk("run_ndone", n_done - b_done, 1);
    chk("run_err", err_o, 0);

    // finish while idle
    snap();
    acc_finish_i = 1'b1; step(); acc_finish_i = 1'b0; step(); step();
    chk("idlefin_busy", busy_o, 0);
    chk("idlefin_nstart", n_start - b_start, 0);
    chk("idlefin_ndone", n_done - b_done, 0);

    // zero-layer run
    snap();
    start_i = 1'b1; num_layers_i = 8'd0;
    step();
    start_i = 1'b0;
    chk("zero_done", done_o, 1); chk("zero_cs", desc_cs_o, 0);
    step();
    chk("zero_done_len", done_o, 0); chk("zero_busy", busy_o, 0);
    step();
    chk("zero_ncs", n_cs - b_cs, 0);
    chk("zero_nstart", n_start - b_start, 0);
    chk("zero_ndone", n_done - b_done, 1);

    // reserved mode on layer 1
    mem[2] = 32'h1234_567F;
    snap();
    start_i = 1'b1; num_layers_i = 8'd3;
    step();
    start_i = 1'b0;
    repeat (3) step();
    chk("rsvd_l0_start", acc_start_o, 1);
    repeat (10) step();
    acc_finish_i = 1'b1; step(); acc_finish_i = 1'b0;
    repeat (3) step();
    chk("rsvd_err", err_o, 1); chk("rsvd_busy_err", busy_o, 1); chk("rsvd_nostart", acc_start_o, 0);
    step();
    chk("rsvd_busy_fall", busy_o, 0); chk("rsvd_err_sticky", err_o, 1);
    step();
    chk("rsvd_nstart", n_start - b_start, 1);
    chk("rsvd_ndone", n_done - b_done, 0);
    mem[2] = 32'h0000_0002;

    // valid start clears err, then watchdog expiry with no finish
    snap();
    start_i = 1'b1; num_layers_i = 8'd1;
    step();
    start_i = 1'b0;
    chk("to_err_cleared", err_o, 0);
    repeat (3) step();
    chk("to_accstart", acc_start_o, 1);
    repeat (50) step();
    chk("to_err_before", err_o, 0); chk("to_busy_before", busy_o, 1);
    step();
    chk("to_err", err_o, 1); chk("to_busy_err", busy_o, 1);
    step();
    chk("to_busy_fall", busy_o, 0); chk("to_err_sticky", err_o, 1);
    step();
    chk("to_ndone", n_done - b_done, 0);

    // finish in the expiry cycle counts as finish
    snap();
    start_i = 1'b1; num_layers_i = 8'd1;
    step();
    start_i = 1'b0;
    repeat (3) step();
    repeat (50) step();
    acc_finish_i = 1'b1;
    step();
    acc_finish_i = 1'b0;
    chk("race_done", done_o, 1); chk("race_err", err_o, 0);
    step();
    chk("race_busy_fall", busy_o, 0);

    // abort during WAIT of layer 1 of 3, then a late finish
    snap();
    start_i = 1'b1; num_layers_i = 8'd3;
    step();
    start_i = 1'b0;
    repeat (3) step();
    repeat (10) step();
    acc_finish_i = 1'b1; step(); acc_finish_i = 1'b0;
    repeat (3) step();
    chk("abort_l1_start", acc_start_o, 1); chk("abort_l1_idx", layer_idx_o, 1);
    repeat (3) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    step();
    acc_finish_i = 1'b1; step(); acc_finish_i = 1'b0;
    repeat (3) step();
    chk("abort_busy_late", busy_o, 0);
    chk("abort_ndone", n_done - b_done, 0);
    chk("abort_nstart", n_start - b_start, 2);
    chk("abort_err", err_o, 0);

    // reset in the middle of a run
    start_i = 1'b1; num_layers_i = 8'd3;
    step();
    start_i = 1'b0;
    step();
    chk("mid_cs_before", desc_cs_o, 1);
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
